// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared constants and types for the board IO input stages.
//   IO_WIDTH            : width of the CPU io_rdata path (switch vector width)
//   IO_SYNC_STAGES      : default flop depth of the input synchronisers
//   IO_DEBOUNCE_CYCLES  : default number of stable clocks before a commit
//   io_deb_state_t      : debouncer FSM state encoding
// -----------------------------------------------------------------------------
package io_pkg;

    localparam int IO_WIDTH           = 24;
    localparam int IO_SYNC_STAGES     = 2;
    localparam int IO_DEBOUNCE_CYCLES = 20000;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        SETTLING = 1'b1
    } io_deb_state_t;

endpackage : io_pkg

// File: rtl/io_sync.sv
// -----------------------------------------------------------------------------
// io_sync
// WIDTH x SYNC_STAGES flop chain that brings asynchronous board inputs into
// the clk domain. Each bit is synchronised independently; multi-bit coherence
// is the job of whatever sits downstream (e.g. the debouncer).
// Ports:
//   clk  : destination clock
//   rst  : asynchronous active-low reset, clears every stage
//   d    : asynchronous input vector
//   q    : synchronised output (d delayed by SYNC_STAGES clk edges)
// -----------------------------------------------------------------------------
module io_sync
    import io_pkg::*;
#(
    parameter int WIDTH       = IO_WIDTH,
    parameter int SYNC_STAGES = IO_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [SYNC_STAGES];

    // Shift the input through the synchroniser chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[SYNC_STAGES-1];

endmodule : io_sync

// File: rtl/io_switch_debouncer.sv
// -----------------------------------------------------------------------------
// io_switch_debouncer
// Synchronises the raw board switches into clk, debounces them as a single
// vector and presents a registered, glitch-free value to the CPU IO read path.
// A sticky 'changed' flag reports that a new value was committed since the
// last CPU read.
//
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   sw_raw    : raw switches, asynchronous to clk
//   rd_en     : one-cycle CPU read strobe, clears 'changed'
//   io_rdata  : committed switch value (registered)
//   changed   : sticky "committed value differs from last read"
//   settling  : high while a candidate value is being timed
//
// Build option:
//   IO_DEBOUNCE_BYPASS_EN : when defined, the FSM and counter are removed and
//                           io_rdata follows the synchronised switches every
//                           clock (fast CPU simulation).
// -----------------------------------------------------------------------------
module io_switch_debouncer
    import io_pkg::*;
#(
    parameter int WIDTH           = IO_WIDTH,
    parameter int SYNC_STAGES     = IO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             rd_en,
    output logic [WIDTH-1:0] io_rdata,
    output logic             changed,
    output logic             settling
);

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] io_rdata_r;
    logic             changed_r;

    io_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_raw),
        .q   (sync_s)
    );

`ifdef IO_DEBOUNCE_BYPASS_EN

    // Pass the synchronised value straight through; flag any difference.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_rdata_r <= {WIDTH{1'b0}};
            changed_r  <= 1'b0;
        end else begin
            io_rdata_r <= sync_s;
            // A set on the same edge as a read must win so no update is lost.
            if (sync_s != io_rdata_r) begin
                changed_r <= 1'b1;
            end else if (rd_en) begin
                changed_r <= 1'b0;
            end else begin
                changed_r <= changed_r;
            end
        end
    end

    assign settling = 1'b0;

`else

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    io_deb_state_t    state_r;
    io_deb_state_t    state_s;
    logic [WIDTH-1:0] cand_r;
    logic [WIDTH-1:0] cand_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             commit_s;

    // Next-state logic: track one candidate vector and count its stable clocks.
    always_comb begin
        state_s  = state_r;
        cand_s   = cand_r;
        cnt_s    = cnt_r;
        commit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync_s != io_rdata_r) begin
                    cand_s  = sync_s;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = SETTLING;
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLING: begin
                if (sync_s == io_rdata_r) begin
                    // Glitch reverted to the committed value: drop the candidate.
                    state_s = IDLE;
                end else if (sync_s != cand_r) begin
                    // Any bit moved: restart timing for the whole vector.
                    cand_s  = sync_s;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = SETTLING;
                end else if (cnt_r == CNT_LAST) begin
                    commit_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                    state_s = SETTLING;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM, candidate and settle-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cand_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cand_r  <= cand_s;
            cnt_r   <= cnt_s;
        end
    end

    // Committed value and sticky change flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_rdata_r <= {WIDTH{1'b0}};
            changed_r  <= 1'b0;
        end else begin
            if (commit_s) begin
                io_rdata_r <= cand_r;
            end else begin
                io_rdata_r <= io_rdata_r;
            end
            // A commit on the same edge as a read must win so no update is lost.
            if (commit_s) begin
                changed_r <= 1'b1;
            end else if (rd_en) begin
                changed_r <= 1'b0;
            end else begin
                changed_r <= changed_r;
            end
        end
    end

    assign settling = (state_r == SETTLING);

`endif

    assign io_rdata = io_rdata_r;
    assign changed  = changed_r;

endmodule : io_switch_debouncer

// File: tb/tb_io_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_io_switch_debouncer
// Directed bench for io_switch_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=8).
// A run-length model says: a value differing from the committed one is
// committed once it has been seen by the debouncer on DEBOUNCE_CYCLES+1
// consecutive edges. The model is compared against the DUT every cycle;
// literal expectations pin the latency and flag behaviour.
// -----------------------------------------------------------------------------
module tb_io_switch_debouncer;

    localparam int W  = 24;
    localparam int S  = 2;
    localparam int DC = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] sw_raw = 24'h000000;
    logic         rd_en = 1'b0;
    logic [W-1:0] io_rdata;
    logic         changed;
    logic         settling;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b1;

    always #10 clk = ~clk;

    io_switch_debouncer #(
        .WIDTH           (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_raw   (sw_raw),
        .rd_en    (rd_en),
        .io_rdata (io_rdata),
        .changed  (changed),
        .settling (settling)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_pipe [S];
    logic [W-1:0] m_io = 24'h000000;
    logic [W-1:0] m_val = 24'h000000;
    logic [W-1:0] m_seen;
    int           m_run = 0;
    logic         m_changed = 1'b0;
    logic         m_commit;

    initial begin
        for (int i = 0; i < S; i++) m_pipe[i] = 24'h000000;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int i = 0; i < S; i++) m_pipe[i] = 24'h000000;
                m_io = 24'h000000; m_val = 24'h000000; m_run = 0; m_changed = 1'b0;
            end else begin
                m_seen   = m_pipe[S-1];
                m_commit = 1'b0;
                if (m_seen == m_io) begin
                    m_run = 0;
                end else if (m_run > 0 && m_seen == m_val) begin
                    m_run++;
                end else begin
                    m_run = 1;
                    m_val = m_seen;
                end
                if (m_run == DC + 1) begin
                    m_commit = 1'b1;
                    m_io     = m_val;
                    m_run    = 0;
                end
                if (m_commit) m_changed = 1'b1;
                else if (rd_en) m_changed = 1'b0;
                for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
                m_pipe[0] = sw_raw;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (cmp_on) begin
                chk("model_io_rdata", 32'(io_rdata), 32'(m_io));
                chk("model_changed", 32'(changed), 32'(m_changed));
                chk("model_settling", 32'(settling), 32'(m_run > 0));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic read_pulse();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    initial begin
        int settle_cnt;
        bit saw_mid;

        // Reset state
        tick(3);
        #1;
        chk("reset_io_rdata", 32'(io_rdata), 32'h0);
        chk("reset_changed", 32'(changed), 32'h0);
        chk("reset_settling", 32'(settling), 32'h0);
        rst = 1'b1;

        // 1. idle after reset with switches at zero
        for (int k = 0; k < 20; k++) begin
            tick(1);
            chk("t1_io_rdata", 32'(io_rdata), 32'h0);
            chk("t1_changed", 32'(changed), 32'h0);
            chk("t1_settling", 32'(settling), 32'h0);
        end

        // 2. clean step, 11-edge latency, 8 settling cycles
        sw_raw = 24'hA5A5A5;
        settle_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (settling) settle_cnt++;
        end
        chk("t2_before_commit", 32'(io_rdata), 32'h0);
        tick(1);
        chk("t2_commit_value", 32'(io_rdata), 32'h00A5A5A5);
        chk("t2_changed", 32'(changed), 32'h1);
        chk("t2_settling_cycles", 32'(settle_cnt), 32'd8);
        read_pulse();
        chk("t2_read_clears", 32'(changed), 32'h0);

        // back to zero
        sw_raw = 24'h000000;
        tick(15);
        chk("back0_io_rdata", 32'(io_rdata), 32'h0);
        read_pulse();

        // 3. short glitch is rejected
        sw_raw = 24'h000001;
        tick(3);
        sw_raw = 24'h000000;
        tick(15);
        chk("t3_io_rdata", 32'(io_rdata), 32'h0);
        chk("t3_changed", 32'(changed), 32'h0);
        chk("t3_settling", 32'(settling), 32'h0);

        // 4. bounce 1/3/1 then hold 3
        saw_mid = 1'b0;
        sw_raw = 24'h000001; for (int k = 0; k < 4; k++) begin tick(1); if (io_rdata != 24'h0) saw_mid = 1'b1; end
        sw_raw = 24'h000003; for (int k = 0; k < 4; k++) begin tick(1); if (io_rdata != 24'h0) saw_mid = 1'b1; end
        sw_raw = 24'h000001; for (int k = 0; k < 4; k++) begin tick(1); if (io_rdata != 24'h0) saw_mid = 1'b1; end
        sw_raw = 24'h000003;
        for (int k = 0; k < 10; k++) begin tick(1); if (io_rdata != 24'h0) saw_mid = 1'b1; end
        chk("t4_no_intermediate", 32'(saw_mid), 32'h0);
        tick(1);
        chk("t4_commit_value", 32'(io_rdata), 32'h00000003);
        chk("t4_changed", 32'(changed), 32'h1);
        read_pulse();

        // 5. read on the commit edge: set wins
        sw_raw = 24'hFFFFFF;
        tick(10);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("t5_commit_value", 32'(io_rdata), 32'h00FFFFFF);
        chk("t5_set_wins", 32'(changed), 32'h1);
        tick(2);
        read_pulse();
        chk("t5_lone_read", 32'(changed), 32'h0);

        // 6. reset mid-settle aborts, then fresh commit
        sw_raw = 24'h00F00F;
        tick(8);
        chk("t6_settling_before_rst", 32'(settling), 32'h1);
        rst = 1'b0;
        #1;
        chk("t6_rst_io_rdata", 32'(io_rdata), 32'h0);
        chk("t6_rst_settling", 32'(settling), 32'h0);
        chk("t6_rst_changed", 32'(changed), 32'h0);
        tick(2);
        rst = 1'b1;
        tick(10);
        chk("t6_before_commit", 32'(io_rdata), 32'h0);
        tick(1);
        chk("t6_commit_value", 32'(io_rdata), 32'h0000F00F);
        chk("t6_changed", 32'(changed), 32'h1);

        tick(2);
        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_io_switch_debouncer
